mdu: RTL

- Multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same A/B operands the register file drives into the ALU.
- Holds the HI/LO architectural registers, which feed the EX result mux for mfhi/mflo.
- Multi-cycle: a start pulse launches an operation and busy covers its latency; the pipeline stalls on (start | busy) when a following md instruction arrives.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/md_calc.sv | 48 ++++
 rtl/mdu.sv | 109 ++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared md_op encodings and default latencies for the multiply/divide unit
// and for the decode logic that drives md_op.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. Signed divide works on magnitudes so
// that 0x80000000 / -1 wraps cleanly instead of overflowing a signed divider.
module md_calc
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_by_zero
);

    logic signed [63:0] sa64, sb64;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        a_mag, b_mag, b_safe, b_mag_safe;
    logic [31:0]        uq, ur, mq, mr, sq, sr;

    always_comb begin
        sa64       = {{32{a[31]}}, a};
        sb64       = {{32{b[31]}}, b};
        prod_s     = sa64 * sb64;
        prod_u     = {32'd0, a} * {32'd0, b};
        a_mag      = a[31] ? (32'd0 - a) : a;
        b_mag      = b[31] ? (32'd0 - b) : b;
        // Divisor forced non-zero so the datapath is defined; the flag suppresses commit.
        b_safe     = (b == 32'd0) ? 32'd1 : b;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq         = a / b_safe;
        ur         = a % b_safe;
        mq         = a_mag / b_mag_safe;
        mr         = a_mag % b_mag_safe;
        sq         = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
        sr         = a[31] ? (32'd0 - mr) : mr;

        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MD_MULT:  {hi_res, lo_res} = prod_s;
            MD_MULTU: {hi_res, lo_res} = prod_u;
            MD_DIV:   begin hi_res = sr; lo_res = sq; end
            MD_DIVU:  begin hi_res = ur; lo_res = uq; end
            default:  ;
        endcase
        div_by_zero = is_div(op) && (b == 32'd0);
    end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: computes the result at the start edge, holds it
// pending for the op latency, then commits it to HI/LO.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [63:0]        pend_q, pend_d;
    logic               pend_dz_q, pend_dz_d;

    logic [31:0]        hi_res, lo_res;
    logic               div_by_zero;

    md_calc u_calc (
        .a           (A),
        .b           (B),
        .op          (md_op),
        .hi_res      (hi_res),
        .lo_res      (lo_res),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_dz_d = pend_dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mult(md_op) || is_div(md_op)) begin
                        pend_d    = {hi_res, lo_res};
                        pend_dz_d = div_by_zero;
                        cnt_d     = is_mult(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy_d    = 1'b1;
                        state_d   = S_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = A;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_RUN: begin
                // start is ignored here: nothing can disturb an in-flight op.
                if (cnt_q == CNT_W'(1)) begin
                    if (!pend_dz_q) begin
                        {hi_d, lo_d} = pend_q;
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
